bht_port_ctrl: RTL and testbench

//  Sequences all accesses to the single-ported 1-bit branch history table (BHT). Arbitrates
//  IF-stage lookups against EX-stage resolved-branch updates, buffering updates in a small

---
 rtl/bht_port_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_bht_port_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bht_port_ctrl.sv
// bht_port_ctrl -- access sequencer for the single-ported 1-bit branch history table.
//
// Purpose
//   Arbitrates IF-stage lookups against EX-stage resolved-branch updates on the one
//   BHT SRAM port. Updates are buffered in a small FIFO and drained when the port is
//   free, or forcibly when the FIFO fills (fetch stalls for that cycle). After reset
//   or flush the whole table is cleared to NOT_TAKEN, one entry per cycle.
//
// Configuration
//   BHT_FWD_EN  when defined, a granted lookup also searches the queued updates for its
//               index and the youngest match overrides the (stale) SRAM data.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   flush                    drop queued updates and re-clear the table
//   lk_req/lk_idx            lookup request from IF
//   lk_gnt                   lookup accepted this cycle (combinational)
//   lk_valid/lk_taken        prediction, one cycle after lk_gnt
//   upd_valid/idx/taken      resolved branch from EX
//   upd_ready                update FIFO can accept (combinational)
//   busy                     clear sequence in progress
//   tbl_en/we/addr/wdata     SRAM request
//   tbl_rdata                SRAM read data, cycle after a read
module bht_port_ctrl #(
    parameter int IDX_W  = 6,
    parameter int QDEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             lk_req,
    input  logic [IDX_W-1:0] lk_idx,
    output logic             lk_gnt,
    output logic             lk_valid,
    output logic             lk_taken,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    output logic             upd_ready,
    output logic             busy,
    output logic             tbl_en,
    output logic             tbl_we,
    output logic [IDX_W-1:0] tbl_addr,
    output logic             tbl_wdata,
    input  logic             tbl_rdata
);

    localparam int AW = $clog2(QDEPTH);
    localparam int PW = AW + 1;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             taken;
    } upd_t;

    state_t           state;
    logic [IDX_W-1:0] clr_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    upd_t             fifo [QDEPTH];
    upd_t             head;

    logic run;
    logic empty;
    logic full;
    logic push;
    logic do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign run   = (state == S_RUN);
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = fifo[rd_ptr[AW-1:0]];

    assign busy      = !run;
    assign upd_ready = run && !full;
    assign lk_gnt    = run && !full && lk_req;

    // A full FIFO takes the port ahead of fetch; otherwise drain only when fetch is idle.
    // Nothing is popped on a flush cycle since the queue is being discarded.
    assign do_pop = run && !flush && (full || (!lk_req && !empty));
    assign push   = upd_valid && upd_ready && !flush;

    // SRAM request. Held fully inactive while reset is asserted, even though the
    // state register already sits in CLEAR.
    always_comb begin
        tbl_en    = 1'b0;
        tbl_we    = 1'b0;
        tbl_addr  = '0;
        tbl_wdata = 1'b0;
        if (rst) begin
            tbl_en = 1'b0;
        end else if (!run) begin
            tbl_en   = 1'b1;
            tbl_we   = 1'b1;
            tbl_addr = clr_ptr;
        end else if (do_pop) begin
            tbl_en    = 1'b1;
            tbl_we    = 1'b1;
            tbl_addr  = head.idx;
            tbl_wdata = head.taken;
        end else if (lk_gnt) begin
            tbl_en   = 1'b1;
            tbl_addr = lk_idx;
        end
    end

    // Control state: clear sequencer, FIFO pointers, response valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_CLEAR;
            clr_ptr  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            lk_valid <= 1'b0;
        end else if (flush) begin
            state    <= S_CLEAR;
            clr_ptr  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            lk_valid <= 1'b0;
        end else begin
            lk_valid <= lk_gnt;
            case (state)
                S_CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (&clr_ptr)
                        state <= S_RUN;
                end
                S_RUN: begin
                    if (push)
                        wr_ptr <= wr_ptr + 1'b1;
                    if (do_pop)
                        rd_ptr <= rd_ptr + 1'b1;
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

    // FIFO storage needs no reset: occupancy is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (push)
            fifo[wr_ptr[AW-1:0]] <= '{idx: upd_idx, taken: upd_taken};
    end

`ifdef BHT_FWD_EN
    logic [PW-1:0] count;
    logic          srch_hit;
    logic          srch_taken;
    logic          fwd_hit;
    logic          fwd_taken;
    upd_t          slot;

    assign count = wr_ptr - rd_ptr;

    // Walk queued entries oldest to youngest so the last match wins. A same-cycle
    // push is not yet in storage and so is naturally excluded.
    always_comb begin
        srch_hit   = 1'b0;
        srch_taken = 1'b0;
        slot       = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            slot = fifo[rd_ptr[AW-1:0] + AW'(i)];
            if ((PW'(i) < count) && (slot.idx == lk_idx)) begin
                srch_hit   = 1'b1;
                srch_taken = slot.taken;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_hit   <= 1'b0;
            fwd_taken <= 1'b0;
        end else if (flush) begin
            fwd_hit   <= 1'b0;
            fwd_taken <= 1'b0;
        end else if (lk_gnt) begin
            fwd_hit   <= srch_hit;
            fwd_taken <= srch_taken;
        end
    end

    assign lk_taken = lk_valid && (fwd_hit ? fwd_taken : tbl_rdata);
`else
    assign lk_taken = lk_valid && tbl_rdata;
`endif

endmodule

// File: tb/tb_bht_port_ctrl.sv
// Randomized bench for bht_port_ctrl. A behavioural SRAM sits on the table port and a
// queue-based reference model predicts every port response cycle by cycle.
module tb_bht_port_ctrl;

    localparam int IDX_W  = 6;
    localparam int QDEPTH = 4;
    localparam int N      = 1 << IDX_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             lk_req = 1'b0;
    logic [IDX_W-1:0] lk_idx = '0;
    logic             lk_gnt, lk_valid, lk_taken;
    logic             upd_valid = 1'b0;
    logic [IDX_W-1:0] upd_idx = '0;
    logic             upd_taken = 1'b0;
    logic             upd_ready, busy;
    logic             tbl_en, tbl_we, tbl_wdata;
    logic [IDX_W-1:0] tbl_addr;
    logic             tbl_rdata;

    always #5 clk = ~clk;

    bht_port_ctrl #(.IDX_W(IDX_W), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .lk_req(lk_req), .lk_idx(lk_idx), .lk_gnt(lk_gnt),
        .lk_valid(lk_valid), .lk_taken(lk_taken),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_ready(upd_ready), .busy(busy),
        .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
        .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata)
    );

    // Single-ported SRAM, read data one cycle after the read.
    logic mem [N];
    always @(posedge clk) begin
        if (tbl_en) begin
            if (tbl_we) mem[tbl_addr] <= tbl_wdata;
            else        tbl_rdata     <= mem[tbl_addr];
        end
    end

    // Reference model state.
    typedef struct {
        int idx;
        bit taken;
    } ent_t;

    ent_t q[$];
    bit   ref_tbl [N];
    int   clr_left;
    bit   exp_vld, exp_tkn;
    bit   clr_chk;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, expv, $time);
        end
    endtask

    task automatic model_restart();
        clr_left = N;
        q.delete();
        foreach (ref_tbl[k]) ref_tbl[k] = 1'b0;
        exp_vld = 1'b0;
        exp_tkn = 1'b0;
    endtask

    // Entered and left on a falling edge. Inputs change mid-reset so the checks show
    // they have no effect on the outputs.
    task automatic do_reset(input int cycles);
        rst       = 1'b1;
        lk_req    = 1'($urandom);
        upd_valid = 1'($urandom);
        flush     = 1'b0;
        #1;
        chk("rst_busy", busy, 1);
        chk("rst_lk_gnt", lk_gnt, 0);
        chk("rst_lk_valid", lk_valid, 0);
        chk("rst_lk_taken", lk_taken, 0);
        chk("rst_upd_ready", upd_ready, 0);
        chk("rst_tbl_en", tbl_en, 0);
        chk("rst_tbl_we", tbl_we, 0);
        chk("rst_tbl_addr", tbl_addr, 0);
        chk("rst_tbl_wdata", tbl_wdata, 0);
        model_restart();
        clr_chk = 1'b0;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock cycle: drive, check against the model, advance the model.
    task automatic step(input bit lr, input int li, input bit uv, input int ui,
                        input bit ut, input bit fl);
        bit busy_e, full_e, gnt_e, pop_e, nv, nt;
        int nz;
        lk_req    = lr;
        lk_idx    = IDX_W'(li);
        upd_valid = uv;
        upd_idx   = IDX_W'(ui);
        upd_taken = ut;
        flush     = fl;
        #1;
        if (clr_chk) begin
            nz = 0;
            foreach (mem[k]) if (mem[k] !== 1'b0) nz++;
            chk("clear_all_zero", nz, 0);
            clr_chk = 1'b0;
        end
        chk("lk_valid", lk_valid, exp_vld);
        chk("lk_taken", lk_taken, exp_vld ? exp_tkn : 1'b0);

        busy_e = (clr_left > 0);
        full_e = (q.size() == QDEPTH);
        gnt_e  = !busy_e && !full_e && lr;
        pop_e  = !busy_e && !fl && (full_e || (!lr && q.size() > 0));
        chk("busy", busy, busy_e);
        chk("upd_ready", upd_ready, !busy_e && !full_e);
        chk("lk_gnt", lk_gnt, gnt_e);

        if (!fl) begin
            if (busy_e) begin
                chk("clr_en", tbl_en, 1);
                chk("clr_we", tbl_we, 1);
                chk("clr_addr", tbl_addr, N - clr_left);
                chk("clr_wdata", tbl_wdata, 0);
            end else if (pop_e) begin
                chk("wr_en", tbl_en, 1);
                chk("wr_we", tbl_we, 1);
                chk("wr_addr", tbl_addr, q[0].idx);
                chk("wr_data", tbl_wdata, q[0].taken);
            end else if (gnt_e) begin
                chk("rd_en", tbl_en, 1);
                chk("rd_we", tbl_we, 0);
                chk("rd_addr", tbl_addr, li);
            end else begin
                chk("idle_en", tbl_en, 0);
            end
        end

        nv = 1'b0;
        nt = 1'b0;
        if (fl) begin
            model_restart();
        end else if (busy_e) begin
            clr_left--;
            if (clr_left == 0) clr_chk = 1'b1;
        end else begin
            if (gnt_e) begin
                nv = 1'b1;
                nt = ref_tbl[li];
`ifdef BHT_FWD_EN
                foreach (q[k]) if (q[k].idx == li) nt = q[k].taken;
`endif
            end
            if (pop_e) begin
                ref_tbl[q[0].idx] = q[0].taken;
                void'(q.pop_front());
            end
            if (uv && !full_e) q.push_back('{idx: ui, taken: ut});
        end
        exp_vld = nv;
        exp_tkn = nt;
        @(negedge clk);
    endtask

    initial begin
        int lk_pct, up_pct, fl_permil, idx_max, drain;
        foreach (mem[k]) mem[k] = 1'($urandom);
        model_restart();
        clr_chk = 1'b0;
        do_reset(2);

        // Phases: light traffic, heavy traffic (FIFO full), narrow index range so
        // lookups hit queued updates, occasional flush, mid-run reset.
        for (int p = 0; p < 6; p++) begin
            case (p)
                0:       begin lk_pct = 30; up_pct = 20; fl_permil = 0;  idx_max = N - 1; end
                1:       begin lk_pct = 95; up_pct = 80; fl_permil = 0;  idx_max = N - 1; end
                2:       begin lk_pct = 70; up_pct = 60; fl_permil = 0;  idx_max = 7;     end
                3:       begin lk_pct = 80; up_pct = 70; fl_permil = 8;  idx_max = 3;     end
                4:       begin lk_pct = 60; up_pct = 50; fl_permil = 4;  idx_max = 15;    end
                default: begin lk_pct = 90; up_pct = 90; fl_permil = 5;  idx_max = 5;     end
            endcase
            for (int c = 0; c < 600; c++) begin
                if (p == 4 && c == 300) begin
                    do_reset(3);
                end else begin
                    step($urandom_range(99) < lk_pct, $urandom_range(idx_max),
                         $urandom_range(99) < up_pct, $urandom_range(idx_max),
                         1'($urandom), $urandom_range(999) < fl_permil);
                end
            end
        end

        // Drain the queue and any clear, then the SRAM must match the model table.
        drain = 0;
        while ((q.size() > 0 || clr_left > 0 || exp_vld) && drain < 200) begin
            step(0, 0, 0, 0, 0, 0);
            drain++;
        end
        chk("drain_timeout", drain < 200, 1);
        step(0, 0, 0, 0, 0, 0);
        foreach (mem[k]) chk($sformatf("mem[%0d]", k), mem[k], ref_tbl[k]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
